// File: rtl/polar64_enc_arbiter.sv
// polar64_enc_arbiter: round-robin front end that shares one non-re-entrant polar64 CRC16
// encoder among four requesters, with an encoder timeout and a sticky spurious-done flag.
module polar64_enc_arbiter #(
  parameter int TIMEOUT_CYC = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [95:0] req_data,
  output logic [3:0]  req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_id,
  output logic [63:0] rsp_codeword,
  output logic        rsp_err,
  output logic        enc_start,
  output logic [23:0] enc_data,
  input  logic        enc_done,
  input  logic [63:0] enc_codeword,
  output logic        busy,
  output logic        spurious_done
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t      state_q, state_d;
  logic [1:0]  last_grant_q, last_grant_d, rsp_id_q, rsp_id_d, gnt;
  logic [23:0] enc_data_q, enc_data_d;
  logic [63:0] rsp_codeword_q, rsp_codeword_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        rsp_err_q, rsp_err_d, rsp_valid_q, rsp_valid_d, spurious_q, spurious_d;
  logic        accept, timeout, in_wait;

  // Scan from lowest to highest priority so the first valid after last_grant wins.
  always_comb begin
    gnt = last_grant_q;
    for (int k = 4; k >= 1; k--)
      gnt = req_valid[last_grant_q + 2'(k)] ? last_grant_q + 2'(k) : gnt;
  end

  assign accept  = (state_q == IDLE) && (|req_valid);
  assign in_wait = state_q == WAIT;
  assign timeout = wait_cnt_q == 8'(TIMEOUT_CYC - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_grant_q   <= 2'd3;
      rsp_id_q       <= '0;
      enc_data_q     <= '0;
      rsp_codeword_q <= '0;
      wait_cnt_q     <= '0;
      rsp_err_q      <= 1'b0;
      rsp_valid_q    <= 1'b0;
      spurious_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      rsp_id_q       <= rsp_id_d;
      enc_data_q     <= enc_data_d;
      rsp_codeword_q <= rsp_codeword_d;
      wait_cnt_q     <= wait_cnt_d;
      rsp_err_q      <= rsp_err_d;
      rsp_valid_q    <= rsp_valid_d;
      spurious_q     <= spurious_d;
    end
  end

  always_comb begin
    state_d = accept                              ? ISSUE :
              (state_q == ISSUE)                  ? WAIT  :
              (in_wait && (enc_done || timeout))  ? RESP  :
              (state_q == RESP && rsp_ready)      ? IDLE  : state_q;
  end

  // enc_done takes precedence over a timeout landing in the same cycle.
  always_comb begin
    last_grant_d   = accept ? gnt : last_grant_q;
    rsp_id_d       = accept ? gnt : rsp_id_q;
    enc_data_d     = accept ? req_data[32'(gnt) * 24 +: 24] : enc_data_q;
    wait_cnt_d     = (state_q == ISSUE) ? 8'd0 : in_wait ? wait_cnt_q + 8'd1 : wait_cnt_q;
    rsp_codeword_d = (in_wait && enc_done) ? enc_codeword : (in_wait && timeout) ? 64'd0 : rsp_codeword_q;
    rsp_err_d      = (in_wait && enc_done) ? 1'b0 : (in_wait && timeout) ? 1'b1 : rsp_err_q;
    rsp_valid_d    = state_d == RESP;
    spurious_d     = spurious_q | (enc_done && !in_wait);
  end

  always_comb begin
    req_ready     = (rst_n && accept) ? 4'b0001 << gnt : 4'b0000;
    enc_start     = state_q == ISSUE;
    busy          = state_q != IDLE;
    rsp_valid     = rsp_valid_q;
    rsp_id        = rsp_id_q;
    rsp_codeword  = rsp_codeword_q;
    rsp_err       = rsp_err_q;
    enc_data      = enc_data_q;
    spurious_done = spurious_q;
  end
endmodule
